// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter (srl/sra/srlv/srav): one bit position per clock, start/done handshake.
// Optional rotate-right mode is enabled by defining SEQ_RSHIFT_ROTATE_EN.
module seq_right_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   number,
  input  logic [SHAMT_W-1:0] shamt,
`ifdef SEQ_RSHIFT_ROTATE_EN
  input  logic               rotate,
`endif
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SHAMT_W-1:0] count;
  logic               mode;
  logic               fill;
`ifdef SEQ_RSHIFT_ROTATE_EN
  logic               rot_mode;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (count == SHAMT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT) || (state == DONE);
    done = (state == DONE);
  end

  // Rotate wins over arithmetic fill when both are captured high.
  always_comb begin
    fill = mode ? result[WIDTH-1] : 1'b0;
`ifdef SEQ_RSHIFT_ROTATE_EN
    if (rot_mode) fill = result[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      count    <= '0;
      mode     <= 1'b0;
`ifdef SEQ_RSHIFT_ROTATE_EN
      rot_mode <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result   <= number;
            count    <= shamt;
            mode     <= arith;
`ifdef SEQ_RSHIFT_ROTATE_EN
            rot_mode <= rotate;
`endif
          end
        end
        SHIFT: begin
          result <= {fill, result[WIDTH-1:1]};
          count  <= count - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed self-checking bench for seq_right_shifter.
// Define SEQ_RSHIFT_ROTATE_EN on both files to also exercise rotate-right.
module tb_seq_right_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [31:0] number;
  logic [4:0]  shamt;
`ifdef SEQ_RSHIFT_ROTATE_EN
  logic        rotate;
`endif
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total  = 0;
  int passed = 0;

  seq_right_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .arith  (arith),
    .number (number),
    .shamt  (shamt),
`ifdef SEQ_RSHIFT_ROTATE_EN
    .rotate (rotate),
`endif
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; arith = 1'b1; number = 32'hDEAD_BEEF; shamt = 5'd3;
`ifdef SEQ_RSHIFT_ROTATE_EN
    rotate = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1; start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result); else passed++;
    tick();
    total++; if (result !== 32'h0 || busy !== 1'b0) $display("FAIL idle_hold got result=%h busy=%b want 00000000/0", result, busy); else passed++;
  endtask

  task automatic test_logical();
    int cyc;
    int busy_bad;
    number = 32'hF000_000F; shamt = 5'd4; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; number = 32'h0; shamt = 5'd0;
    cyc = 1; busy_bad = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_bad++;
      tick(); cyc++;
    end
    if (busy !== 1'b1) busy_bad++;
    total++; if (cyc !== 5) $display("FAIL srl4_latency got %0d want 5", cyc); else passed++;
    total++; if (result !== 32'h0F00_0000) $display("FAIL srl4_result got %h want 0f000000", result); else passed++;
    total++; if (busy_bad !== 0) $display("FAIL srl4_busy got %0d low cycles want 0", busy_bad); else passed++;
    tick();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL srl4_pulse got done=%b busy=%b want 0/0", done, busy); else passed++;
    total++; if (result !== 32'h0F00_0000) $display("FAIL srl4_hold got %h want 0f000000", result); else passed++;
  endtask

  task automatic test_arith();
    int cyc;
    number = 32'h8000_0010; shamt = 5'd4; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; arith = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++; if (cyc !== 5) $display("FAIL sra4_latency got %0d want 5", cyc); else passed++;
    total++; if (result !== 32'hF800_0001) $display("FAIL sra4_result got %h want f8000001", result); else passed++;
    tick();
  endtask

  task automatic test_boundary();
    int cyc;
    number = 32'h1234_5678; shamt = 5'd0; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++; if (cyc !== 1) $display("FAIL shamt0_latency got %0d want 1", cyc); else passed++;
    total++; if (result !== 32'h1234_5678) $display("FAIL shamt0_result got %h want 12345678", result); else passed++;
    tick();
    number = 32'h8000_0000; shamt = 5'd31; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; number = 32'h0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++; if (cyc !== 32) $display("FAIL sra31_latency got %0d want 32", cyc); else passed++;
    total++; if (result !== 32'hFFFF_FFFF) $display("FAIL sra31_result got %h want ffffffff", result); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    number = 32'h0000_00F0; shamt = 5'd2; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++; if (result !== 32'h0000_003C) $display("FAIL b2b_first got %h want 0000003c", result); else passed++;
    // Held during DONE it must be ignored, then taken in the following IDLE cycle.
    number = 32'h8000_0000; shamt = 5'd31; arith = 1'b0; start = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_idle got busy=%b done=%b want 0/0", busy, done); else passed++;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy); else passed++;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++; if (cyc !== 32) $display("FAIL b2b_latency got %0d want 32", cyc); else passed++;
    total++; if (result !== 32'h0000_0001) $display("FAIL b2b_result got %h want 00000001", result); else passed++;
    tick();
  endtask

  task automatic test_ignore_and_reset();
    int cyc;
    int extra_done;
    number = 32'hFFFF_0000; shamt = 5'd10; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    number = 32'h0000_0001; shamt = 5'd1; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 4;
    while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++; if (cyc !== 11) $display("FAIL ignore_latency got %0d want 11", cyc); else passed++;
    total++; if (result !== 32'h003F_FFC0) $display("FAIL ignore_result got %h want 003fffc0", result); else passed++;
    extra_done = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (done === 1'b1) extra_done++; end
    total++; if (extra_done !== 0) $display("FAIL ignore_not_queued got %0d done pulses want 0", extra_done); else passed++;

    number = 32'hAAAA_5555; shamt = 5'd20; arith = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midreset_ctrl got busy=%b done=%b want 0/0", busy, done); else passed++;
    total++; if (result !== 32'h0) $display("FAIL midreset_result got %h want 00000000", result); else passed++;
    extra_done = 0;
    for (int i = 0; i < 25; i++) begin tick(); if (done === 1'b1 || busy === 1'b1) extra_done++; end
    total++; if (extra_done !== 0) $display("FAIL midreset_quiet got %0d active cycles want 0", extra_done); else passed++;
  endtask

`ifdef SEQ_RSHIFT_ROTATE_EN
  task automatic test_rotate();
    int cyc;
    number = 32'h0000_0003; shamt = 5'd1; arith = 1'b1; rotate = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; rotate = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    total++; if (cyc !== 2) $display("FAIL rotr1_latency got %0d want 2", cyc); else passed++;
    total++; if (result !== 32'h8000_0001) $display("FAIL rotr1_result got %h want 80000001", result); else passed++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_boundary();
    test_back_to_back();
    test_ignore_and_reset();
`ifdef SEQ_RSHIFT_ROTATE_EN
    test_rotate();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
